// File: rtl/uart_rx_dword.sv
// rtl/uart_rx_dword.sv - parses LF-terminated ASCII binary lines into 32-bit words
// Optional hex lines ("x" + 8 hex digits) enabled by UART_RX_DWORD_HEX_EN.
module uart_rx_dword #(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_valid,
  input  logic                 i_rd,
  output logic [31:0]          o_data,
  output logic                 o_valid,
  output logic                 o_ovf,
  output logic                 o_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_BIN, S_HEX, S_DISCARD} state_t;

  localparam logic [31:0]          TMO_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
  localparam logic [ERR_CNT_W-1:0] ERR_ONE  = 1;

  state_t                 state_q, state_d;
  logic [5:0]             cnt_q, cnt_d;
  logic [31:0]            sh_q, sh_d;
  logic [31:0]            tmo_q, tmo_d;
  logic [31:0]            data_q;
  logic                   valid_q, ovf_q, err_q;
  logic [ERR_CNT_W-1:0]   err_cnt_q;
  logic                   commit, err_set, tmo_hit;
  logic                   is_bin, is_lf, is_cr, hex_start;

  assign is_bin = (i_rx_data == 8'h30) || (i_rx_data == 8'h31);
  assign is_lf  = (i_rx_data == 8'h0A);
  assign is_cr  = (i_rx_data == 8'h0D);

`ifdef UART_RX_DWORD_HEX_EN
  logic       is_hex;
  logic [3:0] nib;

  assign hex_start = (i_rx_data == 8'h78) || (i_rx_data == 8'h58);

  always_comb begin
    is_hex = 1'b1;
    nib    = i_rx_data[3:0];
    if ((i_rx_data >= 8'h30) && (i_rx_data <= 8'h39)) begin
      nib = i_rx_data[3:0];
    end else if (((i_rx_data >= 8'h61) && (i_rx_data <= 8'h66)) ||
                 ((i_rx_data >= 8'h41) && (i_rx_data <= 8'h46))) begin
      nib = i_rx_data[3:0] + 4'd9;
    end else begin
      is_hex = 1'b0;
    end
  end
`else
  assign hex_start = 1'b0;
`endif

  // A byte arriving in the same cycle always beats the timeout.
  assign tmo_hit = (TIMEOUT_CYCLES > 0) && !i_rx_valid && (state_q != S_IDLE) && (tmo_q == TMO_LAST);
  assign tmo_d   = ((TIMEOUT_CYCLES == 0) || i_rx_valid || (state_q == S_IDLE)) ? 32'd0 : tmo_q + 32'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tmo_hit) begin
      state_d = S_IDLE;
    end else if (i_rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (is_bin)                state_d = S_BIN;
          else if (hex_start)        state_d = S_HEX;
          else if (!(is_lf || is_cr)) state_d = S_DISCARD;
        end
        S_BIN: begin
          if (is_bin)       state_d = (cnt_q == 6'd32) ? S_DISCARD : S_BIN;
          else if (is_lf)   state_d = S_IDLE;
          else if (!is_cr)  state_d = S_DISCARD;
        end
`ifdef UART_RX_DWORD_HEX_EN
        S_HEX: begin
          if (is_hex)       state_d = (cnt_q == 6'd8) ? S_DISCARD : S_HEX;
          else if (is_lf)   state_d = S_IDLE;
          else if (!is_cr)  state_d = S_DISCARD;
        end
`endif
        S_DISCARD: begin
          if (is_lf) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    err_set = 1'b0;
    if (tmo_hit) begin
      err_set = (state_q == S_BIN) || (state_q == S_HEX);
    end else if (i_rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (is_bin) begin
            sh_d  = {sh_q[30:0], i_rx_data[0]};
            cnt_d = 6'd1;
          end else if (hex_start) begin
            cnt_d = 6'd0;
          end else if (!(is_lf || is_cr)) begin
            err_set = 1'b1;
          end
        end
        S_BIN: begin
          if (is_bin) begin
            if (cnt_q == 6'd32) begin
              err_set = 1'b1;
            end else begin
              sh_d  = {sh_q[30:0], i_rx_data[0]};
              cnt_d = cnt_q + 6'd1;
            end
          end else if (is_lf) begin
            commit  = (cnt_q == 6'd32);
            err_set = (cnt_q != 6'd32);
          end else if (!is_cr) begin
            err_set = 1'b1;
          end
        end
`ifdef UART_RX_DWORD_HEX_EN
        S_HEX: begin
          if (is_hex) begin
            if (cnt_q == 6'd8) begin
              err_set = 1'b1;
            end else begin
              sh_d  = {sh_q[27:0], nib};
              cnt_d = cnt_q + 6'd1;
            end
          end else if (is_lf) begin
            commit  = (cnt_q == 6'd8);
            err_set = (cnt_q != 6'd8);
          end else if (!is_cr) begin
            err_set = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q     <= 6'd0;
      sh_q      <= 32'd0;
      tmo_q     <= 32'd0;
      data_q    <= 32'd0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
      tmo_q <= tmo_d;
      err_q <= err_set;
      if (err_set && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + ERR_ONE;
      // A commit takes priority over a same-cycle read acknowledge.
      if (commit) begin
        data_q  <= sh_q;
        valid_q <= 1'b1;
        if (valid_q && !i_rd) ovf_q <= 1'b1;
      end else if (i_rd) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_ovf     = ovf_q;
  assign o_err     = err_q;
  assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_dword.sv
// tb/tb_uart_rx_dword.sv - directed vector bench for uart_rx_dword
module tb_uart_rx_dword;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rd = 1'b0;
  logic [31:0] data;
  logic        valid, ovf, err;
  logic [7:0]  err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int err_pulses = 0;
  int exp_cnt = 0;

  uart_rx_dword #(.TIMEOUT_CYCLES(100), .ERR_CNT_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_rd(rd),
    .o_data(data), .o_valid(valid), .o_ovf(ovf), .o_err(err), .o_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (err) err_pulses++;

  typedef struct {
    string       txt;
    logic [31:0] exp_data;
    logic        exp_valid;
    int          exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_str(input string s, input int gap);
    for (int k = 0; k < s.len(); k++) send_byte(s[k], gap);
  endtask

  task automatic clear_valid();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  function automatic string rep(input string c, input int n);
    string s = "";
    for (int k = 0; k < n; k++) s = {s, c};
    return s;
  endfunction

  initial begin
    vecs[0] = '{"10100101000000001111111100000001", 32'hA500FF01, 1'b1, 0};
    vecs[1] = '{"1111", 32'h0, 1'b0, 1};
    vecs[2] = '{rep("0", 32), 32'h00000000, 1'b1, 0};
    vecs[3] = '{{rep("1", 31), "2", rep("1", 5)}, 32'h0, 1'b0, 1};
    vecs[4] = '{rep("1", 32), 32'hFFFFFFFF, 1'b1, 0};
`ifdef UART_RX_DWORD_HEX_EN
    vecs[5] = '{"xDEADbeef", 32'hDEADBEEF, 1'b1, 0};
`else
    vecs[5] = '{"xDEADbeef", 32'h0, 1'b0, 1};
`endif
    vecs[6] = '{{rep("1", 32), "0"}, 32'h0, 1'b0, 1};
    vecs[7] = '{{"\r1\r", rep("0", 30), "1"}, 32'h80000001, 1'b1, 0};
    vecs[8] = '{"1010a0101", 32'h0, 1'b0, 1};
    vecs[9] = '{"hello", 32'h0, 1'b0, 1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data", data, 32'h0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);

    send_byte(8'h0A, 2);
    for (int i = 0; i < 10; i++) begin
      int e0;
      if (valid) clear_valid();
      e0 = err_pulses;
      send_str(vecs[i].txt, 2);
      chk($sformatf("v%0d_pre_lf_valid", i), {31'd0, valid}, 32'd0);
      send_byte(8'h0A, 0);
      chk($sformatf("v%0d_valid", i), {31'd0, valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) chk($sformatf("v%0d_data", i), data, vecs[i].exp_data);
      repeat (2) @(negedge clk);
      exp_cnt += vecs[i].exp_err;
      chk($sformatf("v%0d_err_pulses", i), err_pulses - e0, vecs[i].exp_err);
      chk($sformatf("v%0d_err_cnt", i), {24'd0, err_cnt}, exp_cnt);
      chk($sformatf("v%0d_ovf", i), {31'd0, ovf}, 32'd0);
    end

    // commit and read acknowledge in the same cycle
    if (!valid) send_str({rep("1", 32), "\n"}, 1);
    send_str(rep("0", 31), 1);
    send_str("1", 1);
    @(negedge clk);
    rx_data = 8'h0A; rx_valid = 1'b1; rd = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rd = 1'b0;
    chk("rdcommit_valid", {31'd0, valid}, 32'd1);
    chk("rdcommit_ovf", {31'd0, ovf}, 32'd0);
    chk("rdcommit_data", data, 32'h00000001);

    // overflow: two more words without acknowledge
    send_str({"11", rep("0", 30), "\n"}, 1);
    send_str({rep("0", 28), "0110", "\n"}, 1);
    @(negedge clk);
    chk("ovf_data", data, 32'h00000006);
    chk("ovf_flag", {31'd0, ovf}, 32'd1);
    clear_valid();
    chk("ovf_rd_valid", {31'd0, valid}, 32'd0);
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);

    // inter-character timeout
    begin
      int e0;
      e0 = err_pulses;
      send_str(rep("1", 9), 1);
      send_byte(8'h31, 0);
      repeat (99) @(negedge clk);
      chk("tmo_early", err_pulses - e0, 0);
      repeat (2) @(negedge clk);
      chk("tmo_pulse", err_pulses - e0, 1);
      chk("tmo_err_cnt", {24'd0, err_cnt}, exp_cnt + 1);
      send_str({rep("0", 31), "1", "\n"}, 1);
      chk("tmo_recover_valid", {31'd0, valid}, 32'd1);
      chk("tmo_recover_data", data, 32'h00000001);
    end

    // reset in the middle of a frame
    begin
      int e0;
      e0 = err_pulses;
      send_str(rep("1", 20), 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_data", data, 32'h0);
      chk("mid_rst_valid", {31'd0, valid}, 32'd0);
      chk("mid_rst_ovf", {31'd0, ovf}, 32'd0);
      chk("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
      repeat (3) @(negedge clk);
      chk("mid_rst_no_err", err_pulses - e0, 0);
      send_str({"1", rep("0", 30), "1", "\n"}, 1);
      chk("post_rst_valid", {31'd0, valid}, 32'd1);
      chk("post_rst_data", data, 32'h80000001);
      chk("post_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
